// File: rtl/tuner_config_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tuner_cfg_pkg
// Description : Shared types and constants for the FM tuner configuration
//               sequencer: FSM states, the 16-bit register word type, the
//               power-up init ROM and the helpers that format tune and
//               volume words.
// Revision    : 1.0 - initial release
// ============================================================================
package tuner_cfg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  typedef logic [15:0] word_t;

  localparam int INIT_DEPTH = 16;

  // Power-up register image; only the first N_INIT entries are replayed.
  localparam word_t INIT_TABLE [INIT_DEPTH] = '{
    16'h0002, 16'hC001, 16'h0000, 16'h888F,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  // Bit that enables tuning in the tune word; the channel sits above it.
  localparam int          TUNE_EN    = 5;
  localparam logic [11:0] VOL_PREFIX = 12'h888;

  function automatic word_t tune_word(input logic [9:0] ch);
    word_t w;
    w          = '0;
    w[15:6]    = ch;
    w[TUNE_EN] = 1'b1;
    return w;
  endfunction

  function automatic word_t vol_word(input logic [3:0] v);
    return {VOL_PREFIX, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tuner_config_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : tuner_config_sequencer_if
// Description : Request/ack bundle between the sequencer and the write-only
//               I2C controller. The sequencer is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface tuner_config_sequencer_if;

  logic [6:0]           i2c_addr;
  tuner_cfg_pkg::word_t i2c_wdata;
  logic                 i2c_req;
  logic                 i2c_ack;

  modport master (
    output i2c_addr,
    output i2c_wdata,
    output i2c_req,
    input  i2c_ack
  );

  modport slave (
    input  i2c_addr,
    input  i2c_wdata,
    input  i2c_req,
    output i2c_ack
  );

endinterface
`default_nettype wire

// File: rtl/tuner_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tuner_config_sequencer
// Description : Replays the tuner init table after reset, then issues tune
//               and volume register writes on demand. Requests coalesce
//               (latest value wins) and are served init > tune > volume.
//               Each write waits for the controller ack (or a timeout) and
//               then holds off for a fixed idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tuner_config_sequencer
  import tuner_cfg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h11,
  parameter int         N_INIT   = 4,
  parameter int         TIMEOUT  = 4096,
  parameter int         GAP      = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [9:0]                       chan,
  input  logic                             chan_valid,
  input  logic [3:0]                       vol,
  input  logic                             vol_valid,
  tuner_config_sequencer_if.master         bus,
  output logic                             busy,
  output logic                             init_done,
  output logic                             err
);

  localparam int                TMR_W    = $clog2(TIMEOUT);
  localparam int                GAP_W    = $clog2(GAP) + 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP - 1);
  localparam logic [3:0]        IDX_LAST = 4'(N_INIT - 1);

  state_t           state_q,     state_d;
  logic [3:0]       idx_q,       idx_d;
  logic             pend_tune_q, pend_tune_d;
  logic             pend_vol_q,  pend_vol_d;
  logic [9:0]       chan_q,      chan_d;
  logic [3:0]       vol_q,       vol_d;
  word_t            wdata_q,     wdata_d;
  logic             req_q,       req_d;
  logic             busy_q,      busy_d;
  logic             init_done_q, init_done_d;
  logic             err_q,       err_d;
  logic [TMR_W-1:0] tmr_q,       tmr_d;
  logic [GAP_W-1:0] gap_q,       gap_d;

  logic             launch;
  logic             clr_tune;
  logic             clr_vol;
  word_t            sel_word;

  assign bus.i2c_addr  = DEV_ADDR;
  assign bus.i2c_wdata = wdata_q;
  assign bus.i2c_req   = req_q;
  assign busy          = busy_q;
  assign init_done     = init_done_q;
  assign err           = err_q;

  // Next-state logic: word selection, launch, ack/timeout wait and gap timing,
  // plus request capture which runs regardless of the FSM state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pend_tune_d = pend_tune_q;
    pend_vol_d  = pend_vol_q;
    chan_d      = chan_q;
    vol_d       = vol_q;
    wdata_d     = wdata_q;
    req_d       = 1'b0;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    tmr_d       = tmr_q;
    gap_d       = gap_q;
    launch      = 1'b0;
    clr_tune    = 1'b0;
    clr_vol     = 1'b0;
    sel_word    = '0;

    case (state_q)
      S_IDLE: begin
        if (!init_done_q) begin
          sel_word = INIT_TABLE[idx_q];
          launch   = 1'b1;
        end else if (pend_tune_q) begin
          sel_word = tune_word(chan_q);
          launch   = 1'b1;
          clr_tune = 1'b1;
        end else if (pend_vol_q) begin
          sel_word = vol_word(vol_q);
          launch   = 1'b1;
          clr_vol  = 1'b1;
        end
        if (launch) begin
          state_d = S_ISSUE;
          wdata_d = sel_word;
          req_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmr_d   = TMR_LOAD;
      end
      S_WAIT: begin
        if (bus.i2c_ack) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (tmr_q == '0) begin
          // No retry: a timed-out word still counts as written.
          err_d   = 1'b1;
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          // While init is pending every transaction is an init word.
          if (!init_done_q) begin
            if (idx_q == IDX_LAST) begin
              init_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A valid arriving in the launch cycle wins over the clear, so the newer
    // value goes out in a later transaction.
    if (clr_tune) begin
      pend_tune_d = 1'b0;
    end
    if (chan_valid) begin
      pend_tune_d = 1'b1;
      chan_d      = chan;
    end
    if (clr_vol) begin
      pend_vol_d = 1'b0;
    end
    if (vol_valid) begin
      pend_vol_d = 1'b1;
      vol_d      = vol;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pend_tune_q <= 1'b0;
      pend_vol_q  <= 1'b0;
      chan_q      <= '0;
      vol_q       <= '0;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      tmr_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_tune_q <= pend_tune_d;
      pend_vol_q  <= pend_vol_d;
      chan_q      <= chan_d;
      vol_q       <= vol_d;
      wdata_q     <= wdata_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      tmr_q       <= tmr_d;
      gap_q       <= gap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tuner_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tuner_config_sequencer
// Description : Self-checking bench for tuner_config_sequencer. An ack model
//               answers each request after a fixed delay; a reference model
//               tracks what the next written word must be from the
//               priority/coalescing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tuner_config_sequencer;

  localparam int GAP     = 64;
  localparam int TIMEOUT = 4096;
  localparam int N_INIT  = 4;
  localparam int ACK_DLY = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  chan;
  logic        chan_valid;
  logic [3:0]  vol;
  logic        vol_valid;
  logic        busy;
  logic        init_done;
  logic        err;

  tuner_config_sequencer_if bus();

  tuner_config_sequencer #(
    .DEV_ADDR (7'h11),
    .N_INIT   (N_INIT),
    .TIMEOUT  (TIMEOUT),
    .GAP      (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chan       (chan),
    .chan_valid (chan_valid),
    .vol        (vol),
    .vol_valid  (vol_valid),
    .bus        (bus),
    .busy       (busy),
    .init_done  (init_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  logic [15:0] exp_init [4] = '{16'h0002, 16'hC001, 16'h0000, 16'h888F};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tune_w(input logic [9:0] c);
    return {c, 1'b1, 5'b00000};
  endfunction

  // ---------------- ack model: pulse ACK_DLY cycles after each req ----------
  int ack_cnt = 0;
  int ack_seen = 0;
  int ack_drop_nth = 0;

  initial begin : ack_model
    bus.i2c_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_cnt = 0; ack_seen = 0; bus.i2c_ack = 1'b0;
      end else begin
        bus.i2c_ack = 1'b0;
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) bus.i2c_ack = 1'b1;
        end
        if (bus.i2c_req) begin
          ack_seen++;
          if (ack_seen != ack_drop_nth) ack_cnt = ACK_DLY;
        end
      end
    end
  end

  // ---------------- reference model + request monitor ----------------------
  int          n_req_rst = 0;
  int          n_req_tot = 0;
  logic [15:0] tx_words [$];
  longint      req_cyc [$];
  bit          m_tune = 0, m_vol = 0;
  logic [9:0]  m_chan = '0;
  logic [3:0]  m_volv = '0;
  int          m_init = 0;
  bit          mon_have;
  logic [15:0] mon_exp;
  logic        prev_req = 1'b0;
  logic [15:0] last_word = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        m_tune = 0; m_vol = 0; m_init = 0; n_req_rst = 0; prev_req = 1'b0;
      end else begin
        // A req seen now was selected from requests captured before the last edge.
        if (bus.i2c_req) begin
          mon_have = 1;
          if (m_init < N_INIT) begin
            mon_exp = exp_init[m_init]; m_init++;
          end else if (m_tune) begin
            mon_exp = tune_w(m_chan); m_tune = 0;
          end else if (m_vol) begin
            mon_exp = {12'h888, m_volv}; m_vol = 0;
          end else begin
            mon_have = 0; mon_exp = '0;
          end
          check("req_has_source", 32'(mon_have), 1);
          if (mon_have) check("wdata", bus.i2c_wdata, mon_exp);
          check("req_single_cycle", prev_req, 0);
          check("addr", bus.i2c_addr, 7'h11);
          n_req_rst++; n_req_tot++;
          tx_words.push_back(bus.i2c_wdata);
          req_cyc.push_back(cyc);
          last_word = bus.i2c_wdata;
        end
        if (bus.i2c_ack && busy) check("wdata_hold", bus.i2c_wdata, last_word);
        prev_req = bus.i2c_req;
        // Requests captured at the last edge land after that edge's launch.
        if (chan_valid) begin m_tune = 1; m_chan = chan; end
        if (vol_valid)  begin m_vol  = 1; m_volv = vol;  end
      end
    end
  end

  // ---------------- helpers ------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req_rst(input int n, input int bound, input string tag);
    int k = 0;
    while (n_req_rst < n && k < bound) begin step(); k++; end
    check(tag, 32'(n_req_rst >= n), 1);
  endtask

  task automatic wait_init(input int bound, input string tag);
    int k = 0;
    while (init_done !== 1'b1 && k < bound) begin step(); k++; end
    check(tag, 32'(init_done), 1);
  endtask

  task automatic wait_quiet(input int bound, input string tag);
    int k = 0;
    int idle = 0;
    while (idle < 6 && k < bound) begin
      step();
      idle = (busy || bus.i2c_req) ? 0 : idle + 1;
      k++;
    end
    check(tag, 32'(idle >= 6), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},       bus.i2c_req,   0);
    check({tag, "_wdata"},     bus.i2c_wdata, 16'h0000);
    check({tag, "_busy"},      busy,          0);
    check({tag, "_init_done"}, init_done,     0);
    check({tag, "_err"},       err,           0);
    check({tag, "_addr"},      bus.i2c_addr,  7'h11);
  endtask

  // ---------------- directed + randomized sequence --------------------------
  int          base;
  int          k;
  logic [9:0]  ch_a, ch_b;
  int          kind;

  initial begin
    reset = 1'b1; chan = '0; chan_valid = 1'b0; vol = '0; vol_valid = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;

    // Init replay with prompt acks.
    wait_req_rst(4, 2000, "init_4_reqs");
    check("init_done_before_last_gap", init_done, 0);
    wait_init(500, "init_done_rise");
    check("busy_low_at_init_done", busy, 0);
    check("init_err", err, 0);
    check("init_req_count", n_req_rst, 4);
    for (int i = 1; i < 4; i++)
      check("init_spacing", 32'((req_cyc[i] - req_cyc[i-1]) >= (GAP + ACK_DLY)), 1);

    // Tune to channel 93: req two cycles after the valid, busy drops GAP after ack.
    chan = 10'd93; chan_valid = 1'b1;
    step();
    check("lat_req_early", bus.i2c_req, 0);
    chan_valid = 1'b0;
    step();
    check("lat_req_at_2", bus.i2c_req, 1);
    check("tune93_word", bus.i2c_wdata, 16'h1760);
    k = 0;
    while (bus.i2c_ack !== 1'b1 && k < 300) begin step(); k++; end
    check("tune93_ack_seen", bus.i2c_ack, 1);
    repeat (GAP) step();
    check("busy_held_through_gap", busy, 1);
    step();
    check("busy_falls_after_gap", busy, 0);

    // Coalescing while busy: two tunes collapse to the last, volume follows.
    base = n_req_tot;
    chan = 10'($urandom_range(0, 1023)); chan_valid = 1'b1;
    step();
    chan_valid = 1'b0;
    k = 0;
    while (n_req_tot < base + 1 && k < 50) begin step(); k++; end
    repeat (10) step();
    chan = 10'd5; chan_valid = 1'b1; step(); chan_valid = 1'b0;
    repeat (5) step();
    chan = 10'd7; chan_valid = 1'b1; step(); chan_valid = 1'b0;
    repeat (5) step();
    vol = 4'd3; vol_valid = 1'b1; step(); vol_valid = 1'b0;
    wait_quiet(2000, "coalesce_quiet");
    check("coalesce_count", n_req_tot - base, 3);
    if (tx_words.size() >= base + 3) begin
      check("coalesce_tune", tx_words[base+1], 16'h01E0);
      check("coalesce_vol",  tx_words[base+2], 16'h8883);
    end

    // Randomized request traffic checked by the reference model.
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 3));
      chan = 10'($urandom_range(0, 1023));
      vol  = 4'($urandom_range(0, 15));
      chan_valid = (kind != 1);
      vol_valid  = (kind != 0);
      step();
      chan_valid = 1'b0; vol_valid = 1'b0;
      repeat ($urandom_range(0, 250)) step();
    end
    wait_quiet(3000, "random_quiet");
    check("random_tune_drained", 32'(m_tune), 0);
    check("random_vol_drained",  32'(m_vol),  0);

    // Valid in the launch cycle of a tune: a second tune carries the new channel.
    base = n_req_tot;
    ch_a = 10'($urandom_range(0, 1023));
    ch_b = ch_a ^ 10'h2AA;
    chan = ch_a; chan_valid = 1'b1;
    step();
    chan = ch_b;
    step();
    chan_valid = 1'b0;
    wait_quiet(2000, "collide_quiet");
    check("collide_count", n_req_tot - base, 2);
    if (tx_words.size() >= base + 2) begin
      check("collide_first",  tx_words[base],   tune_w(ch_a));
      check("collide_second", tx_words[base+1], tune_w(ch_b));
    end

    // Silent controller on the 2nd init word: timeout sets err, init continues.
    reset = 1'b1; step(); step();
    reset = 1'b0;
    ack_drop_nth = 2;
    wait_req_rst(2, 1000, "to_second_req");
    repeat (TIMEOUT) step();
    check("err_not_before_timeout", err, 0);
    step();
    check("err_at_timeout", err, 1);
    check("busy_after_timeout", busy, 1);
    wait_init(2000, "to_init_done");
    check("to_req_count", n_req_rst, 4);
    check("to_err_sticky", err, 1);
    ack_drop_nth = 0;

    // Reset during the wait of init word 2, then restart from the first word.
    reset = 1'b1; step();
    reset = 1'b0;
    wait_req_rst(2, 1000, "mid_second_req");
    repeat (10) step();
    reset = 1'b1;
    step();
    check_reset_outputs("midrst");
    reset = 1'b0;
    wait_req_rst(1, 100, "restart_first_req");
    if (tx_words.size() > 0) check("restart_word", tx_words[tx_words.size()-1], 16'h0002);
    wait_init(2000, "restart_init_done");
    check("restart_req_count", n_req_rst, 4);
    check("restart_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tuner_config_sequencer.md
Name: tuner_config_sequencer

Overview:
Sequences 16-bit register writes to the FM tuner chip through the write-only I²C controller. After reset it replays a fixed init table. It then issues tune and volume writes on demand, with coalescing and fixed priority. It owns the controller's addr/wdata/req inputs and consumes its end-of-transaction ack.

Parameters:
DEV_ADDR, 7'h11, 7-bit I²C device address driven on every transaction
N_INIT, 4, number of words in the init table (1..16)
TIMEOUT, 4096, clk cycles to wait for ack before aborting a transaction
GAP, 64, minimum idle clk cycles between ack and the next req

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
chan  in  10  channel index, sampled when chan_valid=1
chan_valid  in  1  one-cycle tune request
vol  in  4  volume, sampled when vol_valid=1
vol_valid  in  1  one-cycle volume request
i2c_addr  out  7  to controller addr; constant DEV_ADDR
i2c_wdata  out  16  to controller wdata; [15:8] is sent first
i2c_req  out  1  to controller req; one-cycle pulse
i2c_ack  in  1  from controller; one-cycle pulse at end of STOP
busy  out  1  high from req until GAP expires
init_done  out  1  sticky; set after the last init word completes
err  out  1  sticky; set on any ack timeout

Behaviour:
- Reset values: i2c_req=0, i2c_wdata=16'h0000, busy=0, init_done=0, err=0, state=S_IDLE, idx=0, pending flags=0, chan_q=0, vol_q=0. i2c_addr is constant DEV_ADDR at all times.
- Reset mid-transaction: the sequencer returns to S_IDLE at once. The init table restarts from idx 0.
- Request capture, independent of state:
  - chan_valid: chan_q<=chan, pend_tune<=1.
  - vol_valid: vol_q<=vol, pend_vol<=1.
  - Repeated valids before launch coalesce. Only the last value is written.
- Word formats:
  - TUNE word = {chan_q, 1'b1, 5'b00000}.
  - VOL word = {12'h888, vol_q}.
  - INIT words come from the package ROM INIT_TABLE[idx].
- Selection in S_IDLE, in priority order:
  1. init_done=0: select INIT_TABLE[idx].
  2. pend_tune: select the TUNE word.
  3. pend_vol: select the VOL word.
  4. Otherwise stay in S_IDLE.
- Launch, on the S_IDLE->S_ISSUE transition:
  - i2c_wdata is registered with the selected word.
  - The matching pend flag is cleared. If a valid of the same kind arrives in the launch cycle, the flag stays set; the new value is written in a later transaction.
- S_ISSUE:
  - i2c_req=1 for exactly one cycle, busy=1.
  - Goes to S_WAIT; the timer is loaded with TIMEOUT-1.
- S_WAIT:
  - i2c_wdata is held stable until ack.
  - i2c_ack=1: go to S_GAP and load the gap counter with GAP-1.
  - Timer reaches 0 without ack: set err, go to S_GAP. The word counts as complete for advancement; there is no retry.
  - i2c_ack outside S_WAIT is ignored.
- S_GAP:
  - Count down; at 0 go to S_IDLE with busy=0.
  - On leaving S_GAP after an INIT word: idx++. If idx was N_INIT-1, set init_done and stop incrementing idx.
- Latency: valid in S_IDLE with init_done=1 gives i2c_req exactly 2 cycles later (capture cycle, then launch cycle).
- Widths: the timer is $clog2(TIMEOUT) bits and the gap counter is $clog2(GAP)+1 bits. Both saturate at 0 and never wrap.
- err is cleared only by reset.

Decomposition:
- Package tuner_cfg_pkg holds:
  - state enum {S_IDLE, S_ISSUE, S_WAIT, S_GAP};
  - typedef word_t = logic [15:0];
  - INIT_TABLE (word_t array, 16 entries, first N_INIT used; default {16'h0002, 16'hC001, 16'h0000, 16'h888F});
  - TUNE_EN bit position and VOL_PREFIX 12'h888.
- Single module. No sub-module is needed; the word-select mux is inline.

Test Plan:
- Reset, with an ack model that pulses 100 cycles after each req: four reqs carry wdata 0002, C001, 0000, 888F in order. Consecutive reqs are at least GAP+100 cycles apart. init_done rises after the 4th gap.
- After init, chan_valid with chan=10'd93: one req with wdata=16'h1760; busy falls GAP cycles after ack.
- During a busy write, pulse chan_valid with chan=5, then chan=7, then vol_valid with vol=3. Result: exactly two further transactions, TUNE 16'h01E0 first, then VOL 16'h8883.
- Ack model silent on the 2nd init word: err=1 after TIMEOUT cycles, and the 3rd init word is still issued.
- chan_valid in the same cycle as the TUNE launch: a second TUNE transaction carries the new chan.
- Assert reset during S_WAIT of init word 2, then deassert: outputs return to reset values, and the init sequence restarts at 16'h0002.
